psum_spad_ctrl: RTL

- Initiator-side controller for the PE partial-sum scratchpad (synchronous RAM: 64 x 8-bit, one shared address, write has priority over read, registered read data).
- Accepts a stream of (address, product) pairs and does read-modify-write accumulation into the scratchpad.
- On command, drains a contiguous range of partial sums out through a valid/ready port toward the PE output path.
- Sits between the PE multiplier and the scratchpad; it is the only master of the scratchpad ports.

---
 rtl/psum_pkg.sv | 20 ++
 rtl/psum_spad_ctrl_adder.sv | 28 ++
 rtl/psum_spad_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/psum_pkg.sv
// Shared definitions for the PE partial-sum scratchpad controller:
// default widths, saturation limits and the controller state encoding.
package psum_pkg;

   localparam int PSUM_DATA_W = 8;
   localparam int PSUM_ADDR_W = 6;

   localparam logic [PSUM_DATA_W-1:0] PSUM_SAT_MAX = 8'h7F;
   localparam logic [PSUM_DATA_W-1:0] PSUM_SAT_MIN = 8'h80;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ACC_RD  = 3'd1,
      ST_ACC_WR  = 3'd2,
      ST_DRN_RD  = 3'd3,
      ST_DRN_CAP = 3'd4,
      ST_DRN_OUT = 3'd5
   } psum_state_t;

endpackage

// File: rtl/psum_spad_ctrl_adder.sv
// Combinational partial-sum adder: modulo-2^DATA_W wrap, or signed
// two's-complement saturation when SATURATE is set.
module psum_adder #(
   parameter int DATA_W   = 8,
   parameter bit SATURATE = 1'b0
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] sum
);

   logic [DATA_W-1:0] raw;
   assign raw = a + b;

   generate
      if (SATURATE) begin : g_sat
         // Overflow only when both operands share a sign the result lost.
         logic ovf;
         assign ovf = (a[DATA_W-1] == b[DATA_W-1]) && (raw[DATA_W-1] != a[DATA_W-1]);
         assign sum = !ovf          ? raw :
                      a[DATA_W-1]   ? {1'b1, {(DATA_W-1){1'b0}}} :
                                      {1'b0, {(DATA_W-1){1'b1}}};
      end else begin : g_wrap
         assign sum = raw;
      end
   endgenerate

endmodule

// File: rtl/psum_spad_ctrl.sv
// Partial-sum scratchpad controller: read-modify-write accumulation of
// incoming products and valid/ready drain of a contiguous entry range.
module psum_spad_ctrl
   import psum_pkg::*;
#(
   parameter int DATA_W   = PSUM_DATA_W,
   parameter int ADDR_W   = PSUM_ADDR_W,
   parameter bit SATURATE = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic              in_first,
   input  logic              drain_start,
   input  logic [ADDR_W-1:0] drain_len,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic              spad_rd,
   output logic              spad_wr,
   output logic [ADDR_W-1:0] spad_addr,
   output logic [DATA_W-1:0] spad_wdata,
   input  logic [DATA_W-1:0] spad_rdata
);

   psum_state_t       state_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [DATA_W-1:0] data_reg;
   logic [ADDR_W-1:0] len_reg;
   logic [ADDR_W-1:0] ptr_reg;
   logic [DATA_W-1:0] out_data_reg;
   logic [ADDR_W-1:0] out_addr_reg;
   logic              out_last_reg;
   logic              done_reg;
   logic [DATA_W-1:0] sum;
   logic              idle;
   logic              in_fire;

   psum_adder #(
      .DATA_W   (DATA_W),
      .SATURATE (SATURATE)
   ) u_adder (
      .a   (spad_rdata),
      .b   (data_reg),
      .sum (sum)
   );

   // The reset term keeps in_ready low while rst is held, not just after it.
   assign idle      = (state_reg == ST_IDLE) && !rst;
   assign in_ready  = idle && !drain_start;
   assign in_fire   = in_valid && in_ready;
   assign out_valid = (state_reg == ST_DRN_OUT);
   assign busy      = (state_reg != ST_IDLE);
   assign done      = done_reg;
   assign out_data  = out_data_reg;
   assign out_addr  = out_addr_reg;
   assign out_last  = out_last_reg;

   always_comb begin
      spad_rd    = 1'b0;
      spad_wr    = 1'b0;
      spad_addr  = '0;
      spad_wdata = '0;
      case (state_reg)
         ST_IDLE: begin
            if (in_fire) begin
               spad_addr = in_addr;
               if (in_first) begin
                  spad_wr    = 1'b1;
                  spad_wdata = in_data;
               end else begin
                  spad_rd = 1'b1;
               end
            end
         end
         ST_ACC_WR: begin
            spad_wr    = 1'b1;
            spad_addr  = addr_reg;
            spad_wdata = sum;
         end
         ST_DRN_RD: begin
            spad_rd   = 1'b1;
            spad_addr = ptr_reg;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         addr_reg     <= '0;
         data_reg     <= '0;
         len_reg      <= '0;
         ptr_reg      <= '0;
         out_data_reg <= '0;
         out_addr_reg <= '0;
         out_last_reg <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (drain_start) begin
                  len_reg   <= drain_len;
                  ptr_reg   <= '0;
                  state_reg <= ST_DRN_RD;
               end else if (in_valid && !in_first) begin
                  addr_reg  <= in_addr;
                  data_reg  <= in_data;
                  state_reg <= ST_ACC_WR;
               end
            end
            ST_ACC_WR: state_reg <= ST_IDLE;
            ST_DRN_RD: state_reg <= ST_DRN_CAP;
            ST_DRN_CAP: begin
               out_data_reg <= spad_rdata;
               out_addr_reg <= ptr_reg;
               out_last_reg <= (ptr_reg == len_reg);
               state_reg    <= ST_DRN_OUT;
            end
            ST_DRN_OUT: begin
               if (out_ready) begin
                  if (out_last_reg) begin
                     done_reg  <= 1'b1;
                     state_reg <= ST_IDLE;
                  end else begin
                     ptr_reg   <= ptr_reg + 1'b1;
                     state_reg <= ST_DRN_RD;
                  end
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule
